// File: rtl/rtc_calendar_bcd_if.sv
// Bus bundle for the BCD calendar counter: tick/load requests, load fields,
// and the registered date/time outputs with their status pulses.
interface rtc_calendar_bcd_if;
    logic        tick_1hz;
    logic        load;
    logic [15:0] ld_year_bcd;
    logic [7:0]  ld_month_bcd;
    logic [7:0]  ld_day_bcd;
    logic [7:0]  ld_hour_bcd;
    logic [7:0]  ld_minute_bcd;
    logic [7:0]  ld_second_bcd;
    logic [15:0] year_bcd;
    logic [7:0]  month_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  hour_bcd;
    logic [7:0]  minute_bcd;
    logic [7:0]  second_bcd;
    logic        updated;
    logic        load_err;

    // Upstream side drives requests and watches the calendar.
    modport master (
        output tick_1hz, load,
        output ld_year_bcd, ld_month_bcd, ld_day_bcd,
        output ld_hour_bcd, ld_minute_bcd, ld_second_bcd,
        input  year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd,
        input  updated, load_err
    );

    // Calendar side consumes requests and presents the current date/time.
    modport slave (
        input  tick_1hz, load,
        input  ld_year_bcd, ld_month_bcd, ld_day_bcd,
        input  ld_hour_bcd, ld_minute_bcd, ld_second_bcd,
        output year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd,
        output updated, load_err
    );
endinterface

// File: rtl/rtc_calendar_bcd.sv
// BCD real-time calendar: advances one second per tick with Gregorian month
// lengths and leap years, accepts validated atomic loads. All arithmetic is
// done digit-wise on BCD nibbles; no binary copy of the date is kept.
module rtc_calendar_bcd #(
    parameter logic [15:0] RESET_YEAR = 16'h1970,
    parameter logic [15:0] MIN_YEAR   = 16'h1970
) (
    input logic               clk,
    input logic               rst,
    rtc_calendar_bcd_if.slave bus
);

    logic [15:0] year_q,   year_d;
    logic [7:0]  month_q,  month_d;
    logic [7:0]  day_q,    day_d;
    logic [7:0]  hour_q,   hour_d;
    logic [7:0]  minute_q, minute_d;
    logic [7:0]  second_q, second_d;
    logic        updated_q, updated_d;
    logic        load_err_q, load_err_d;
    logic        loadValid;

    // (10*tens + units) mod 4 == (2*tens + units) mod 4, so only the parity
    // of tens and the two low bits of units matter.
    function automatic logic pairDivBy4(input logic [3:0] tens, input logic [3:0] units);
        return (units[0] == 1'b0) && (units[1] == tens[0]);
    endfunction

    // Century years (xx00) use the thousands/hundreds pair instead.
    function automatic logic isLeap(input logic [15:0] y);
        if (y[7:0] == 8'h00)
            return pairDivBy4(y[15:12], y[11:8]);
        return pairDivBy4(y[7:4], y[3:0]);
    endfunction

    function automatic logic [7:0] monthLength(input logic [7:0] m, input logic leap);
        case (m)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] incPair(input logic [7:0] x);
        if (x[3:0] == 4'h9)
            return {x[7:4] + 4'h1, 4'h0};
        return {x[7:4], x[3:0] + 4'h1};
    endfunction

    function automatic logic [15:0] incYear(input logic [15:0] y);
        logic [15:0] r;
        logic        carry;
        r     = y;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'h9) begin
                    r[4*i +: 4] = 4'h0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'h1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic nibblesOk8(input logic [7:0] x);
        return (x[7:4] <= 4'h9) && (x[3:0] <= 4'h9);
    endfunction

    function automatic logic nibblesOk16(input logic [15:0] x);
        return nibblesOk8(x[15:8]) && nibblesOk8(x[7:0]);
    endfunction

    // Load validation; once every nibble is a decimal digit, BCD magnitude
    // compares match numeric compares, so plain relational operators work.
    always_comb begin
        loadValid = nibblesOk16(bus.ld_year_bcd)
                 && nibblesOk8(bus.ld_month_bcd) && nibblesOk8(bus.ld_day_bcd)
                 && nibblesOk8(bus.ld_hour_bcd)  && nibblesOk8(bus.ld_minute_bcd)
                 && nibblesOk8(bus.ld_second_bcd)
                 && (bus.ld_month_bcd >= 8'h01) && (bus.ld_month_bcd <= 8'h12)
                 && (bus.ld_day_bcd >= 8'h01)
                 && (bus.ld_day_bcd <= monthLength(bus.ld_month_bcd, isLeap(bus.ld_year_bcd)))
                 && (bus.ld_hour_bcd <= 8'h23)
                 && (bus.ld_minute_bcd <= 8'h59)
                 && (bus.ld_second_bcd <= 8'h59)
                 && (bus.ld_year_bcd >= MIN_YEAR);
    end

    // Next-state: load wins over tick (and swallows it); tick ripples the carry.
    always_comb begin
        year_d     = year_q;
        month_d    = month_q;
        day_d      = day_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        updated_d  = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (loadValid) begin
                year_d    = bus.ld_year_bcd;
                month_d   = bus.ld_month_bcd;
                day_d     = bus.ld_day_bcd;
                hour_d    = bus.ld_hour_bcd;
                minute_d  = bus.ld_minute_bcd;
                second_d  = bus.ld_second_bcd;
                updated_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.tick_1hz) begin
            updated_d = 1'b1;
            second_d  = incPair(second_q);
            if (second_q == 8'h59) begin
                second_d = 8'h00;
                minute_d = incPair(minute_q);
                if (minute_q == 8'h59) begin
                    minute_d = 8'h00;
                    hour_d   = incPair(hour_q);
                    if (hour_q == 8'h23) begin
                        hour_d = 8'h00;
                        day_d  = incPair(day_q);
                        if (day_q == monthLength(month_q, isLeap(year_q))) begin
                            day_d   = 8'h01;
                            month_d = incPair(month_q);
                            if (month_q == 8'h12) begin
                                month_d = 8'h01;
                                year_d  = (year_q == 16'h9999) ? MIN_YEAR : incYear(year_q);
                            end
                        end
                    end
                end
            end
        end
    end

    // Field and status registers; async reset to the configured epoch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            year_q     <= RESET_YEAR;
            month_q    <= 8'h01;
            day_q      <= 8'h01;
            hour_q     <= 8'h00;
            minute_q   <= 8'h00;
            second_q   <= 8'h00;
            updated_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            year_q     <= year_d;
            month_q    <= month_d;
            day_q      <= day_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            updated_q  <= updated_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.year_bcd   = year_q;
    assign bus.month_bcd  = month_q;
    assign bus.day_bcd    = day_q;
    assign bus.hour_bcd   = hour_q;
    assign bus.minute_bcd = minute_q;
    assign bus.second_bcd = second_q;
    assign bus.updated    = updated_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_rtc_calendar_bcd.sv
// Self-checking bench for rtc_calendar_bcd: directed calendar corner cases
// plus a randomized tick/load mix compared against an integer date model.
module tb_rtc_calendar_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rtc_calendar_bcd_if bus ();

    rtc_calendar_bcd #(
        .RESET_YEAR(16'h1970),
        .MIN_YEAR  (16'h1970)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: plain integers, Gregorian rules.
    int  mY, mMo, mD, mH, mMi, mS;
    bit  expUpd, expErr;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] toBcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] toBcd16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit leapYear(input int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int daysIn(input int y, input int m);
        case (m)
            2:           return leapYear(y) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [55:0] dutFields();
        return {bus.year_bcd, bus.month_bcd, bus.day_bcd,
                bus.hour_bcd, bus.minute_bcd, bus.second_bcd};
    endfunction

    function automatic logic [55:0] modelFields();
        return {toBcd16(mY), toBcd8(mMo), toBcd8(mD), toBcd8(mH), toBcd8(mMi), toBcd8(mS)};
    endfunction

    function automatic bit bcdOk(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcdVal(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    task automatic modelReset();
        mY = 1970; mMo = 1; mD = 1; mH = 0; mMi = 0; mS = 0;
        expUpd = 1'b0; expErr = 1'b0;
    endtask

    task automatic modelEvent(input bit t, input bit l, input logic [15:0] y,
                              input logic [7:0] mo, input logic [7:0] d, input logic [7:0] h,
                              input logic [7:0] mi, input logic [7:0] s);
        int ly, lmo, ld, lh, lmi, ls;
        bit ok;
        expUpd = 1'b0;
        expErr = 1'b0;
        if (l) begin
            ok  = bcdOk(y) && bcdOk({8'h00, mo}) && bcdOk({8'h00, d}) && bcdOk({8'h00, h})
               && bcdOk({8'h00, mi}) && bcdOk({8'h00, s});
            ly  = bcdVal(y);
            lmo = bcdVal({8'h00, mo});
            ld  = bcdVal({8'h00, d});
            lh  = bcdVal({8'h00, h});
            lmi = bcdVal({8'h00, mi});
            ls  = bcdVal({8'h00, s});
            ok  = ok && lmo >= 1 && lmo <= 12 && ld >= 1 && ld <= daysIn(ly, lmo)
               && lh <= 23 && lmi <= 59 && ls <= 59 && ly >= 1970;
            if (ok) begin
                mY = ly; mMo = lmo; mD = ld; mH = lh; mMi = lmi; mS = ls;
                expUpd = 1'b1;
            end else begin
                expErr = 1'b1;
            end
        end else if (t) begin
            expUpd = 1'b1;
            mS++;
            if (mS == 60) begin
                mS = 0; mMi++;
                if (mMi == 60) begin
                    mMi = 0; mH++;
                    if (mH == 24) begin
                        mH = 0; mD++;
                        if (mD > daysIn(mY, mMo)) begin
                            mD = 1; mMo++;
                            if (mMo == 13) begin
                                mMo = 1;
                                mY  = (mY == 9999) ? 1970 : mY + 1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Drives one cycle of stimulus from a falling edge, advances the model on
    // the rising edge, then compares everything on the next falling edge.
    task automatic applyStimulus(input string tag, input bit t, input bit l, input logic [15:0] y,
                                 input logic [7:0] mo, input logic [7:0] d, input logic [7:0] h,
                                 input logic [7:0] mi, input logic [7:0] s);
        bus.tick_1hz      = t;
        bus.load          = l;
        bus.ld_year_bcd   = y;
        bus.ld_month_bcd  = mo;
        bus.ld_day_bcd    = d;
        bus.ld_hour_bcd   = h;
        bus.ld_minute_bcd = mi;
        bus.ld_second_bcd = s;
        @(posedge clk);
        modelEvent(t, l, y, mo, d, h, mi, s);
        @(negedge clk);
        bus.tick_1hz = 1'b0;
        bus.load     = 1'b0;
        checkOutput({tag, ".fields"},   64'(dutFields()),  64'(modelFields()));
        checkOutput({tag, ".updated"},  64'(bus.updated),  64'(expUpd));
        checkOutput({tag, ".load_err"}, 64'(bus.load_err), 64'(expErr));
    endtask

    task automatic tick(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    endtask

    task automatic loadBcd(input string tag, input logic [55:0] v);
        applyStimulus(tag, 1'b0, 1'b1, v[55:40], v[39:32], v[31:24], v[23:16], v[15:8], v[7:0]);
    endtask

    initial begin
        logic [55:0] ldv;
        int r, ry, rmo;
        bus.tick_1hz = 1'b0;
        bus.load     = 1'b0;
        bus.ld_year_bcd = 16'h0;
        bus.ld_month_bcd = 8'h0; bus.ld_day_bcd = 8'h0; bus.ld_hour_bcd = 8'h0;
        bus.ld_minute_bcd = 8'h0; bus.ld_second_bcd = 8'h0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset.fields",   64'(dutFields()),  64'h0019_7001_0100_0000);
        checkOutput("reset.updated",  64'(bus.updated),  64'h0);
        checkOutput("reset.load_err", 64'(bus.load_err), 64'h0);
        rst = 1'b0;

        tick("first_tick");
        checkOutput("first_tick.lit", 64'(dutFields()), 64'h0019_7001_0100_0001);
        idle("pulse_drop");

        loadBcd("ld_2023", 56'h2023_02_28_235959);
        tick("nonleap");
        checkOutput("nonleap.lit", 64'(dutFields()), 64'h0020_2303_0100_0000);

        loadBcd("ld_2024", 56'h2024_02_28_235959);
        tick("leap2024");
        checkOutput("leap2024.lit", 64'(dutFields()), 64'h0020_2402_2900_0000);

        loadBcd("ld_2000", 56'h2000_02_29_235959);
        tick("leap2000");
        checkOutput("leap2000.lit", 64'(dutFields()), 64'h0020_0003_0100_0000);

        loadBcd("ld_2100_bad", 56'h2100_02_29_000000);
        checkOutput("ld_2100_bad.err", 64'(bus.load_err), 64'h1);

        loadBcd("ld_9999", 56'h9999_12_31_235959);
        tick("yearwrap");
        checkOutput("yearwrap.lit", 64'(dutFields()), 64'h0019_7001_0100_0000);

        loadBcd("ld_2024_dec", 56'h2024_12_31_235959);
        tick("newyear");
        checkOutput("newyear.lit", 64'(dutFields()), 64'h0020_2501_0100_0000);

        loadBcd("bad_month",  56'h2024_13_01_000000);
        loadBcd("bad_apr31",  56'h2024_04_31_000000);
        loadBcd("bad_hour",   56'h2024_05_01_240000);
        loadBcd("bad_secnib", 56'h2024_05_01_00000A);
        checkOutput("bad_secnib.lit", 64'(dutFields()), 64'h0020_2501_0100_0000);

        applyStimulus("collide", 1'b1, 1'b1, 16'h2030, 8'h06, 8'h15, 8'h12, 8'h00, 8'h00);
        checkOutput("collide.lit", 64'(dutFields()), 64'h0020_3006_1512_0000);
        applyStimulus("collide_bad", 1'b1, 1'b1, 16'h2030, 8'h02, 8'h30, 8'h12, 8'h00, 8'h00);

        // Randomized mix biased toward end-of-day loads so carries cascade.
        for (int i = 0; i < 800; i++) begin
            r   = $urandom_range(0, 99);
            ry  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 2100 : 9999)
                                              : $urandom_range(1970, 9999);
            rmo = $urandom_range(1, 12);
            ldv = {toBcd16(ry), toBcd8(rmo),
                   toBcd8(($urandom_range(0, 1) == 0) ? daysIn(ry, rmo) : $urandom_range(1, daysIn(ry, rmo))),
                   toBcd8(($urandom_range(0, 1) == 0) ? 23 : $urandom_range(0, 23)),
                   toBcd8(($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59)),
                   toBcd8(($urandom_range(0, 1) == 0) ? 59 - $urandom_range(0, 3) : $urandom_range(0, 59))};
            if (r < 65) begin
                tick("rnd_tick");
            end else if (r < 75) begin
                loadBcd("rnd_load", ldv);
            end else if (r < 85) begin
                ldv[8 * $urandom_range(0, 6) +: 8] = 8'($urandom);
                loadBcd("rnd_garbage", ldv);
            end else if (r < 92) begin
                applyStimulus("rnd_collide", 1'b1, 1'b1, ldv[55:40], ldv[39:32], ldv[31:24],
                              ldv[23:16], ldv[15:8], ldv[7:0]);
            end else begin
                idle("rnd_idle");
            end
        end

        // Asynchronous reset between clock edges.
        loadBcd("pre_rst", 56'h2030_06_15_120000);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst.fields",  64'(dutFields()), 64'h0019_7001_0100_0000);
        checkOutput("async_rst.updated", 64'(bus.updated), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        tick("post_rst");
        checkOutput("post_rst.lit", 64'(dutFields()), 64'h0019_7001_0100_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
